// File: rtl/fft_reorder_stream.sv
// Output stage for the pipelined FFT cores: bit-reversed frames are reordered through
// two ping-pong banks, then rounded/saturated and presented on a valid/ready stream.
module fft_reorder_stream #(
    parameter int LGSIZE     = 11,
    parameter int IWIDTH     = 28,
    parameter int OWIDTH     = 24,
    parameter bit OPT_BITREV = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic                  i_sync,
    input  logic [2*IWIDTH-1:0]   i_sample,
    input  logic [4:0]            i_shift,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*OWIDTH-1:0]   o_result,
    output logic                  o_sync,
    output logic                  o_last,
    output logic                  o_overflow,
    output logic                  o_drop
);

    localparam int N = 1 << LGSIZE;
    localparam logic [LGSIZE-1:0] LAST_ADDR = {LGSIZE{1'b1}};
    localparam logic [LGSIZE-1:0] ONE_ADDR  = LGSIZE'(1);
    localparam logic signed [IWIDTH:0] SAT_HI = (IWIDTH+1)'((1 <<< (OWIDTH-1)) - 1);
    localparam logic signed [IWIDTH:0] SAT_LO = -SAT_HI;
    localparam logic signed [IWIDTH:0] ONE_S  = (IWIDTH+1)'(1);

    typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;

    // Write side
    wr_state_t           wr_state_q, wr_state_d;
    logic [LGSIZE-1:0]   wr_cnt_q, wr_cnt_d, wr_cnt_rev, wr_addr_lo;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          full_q, full_d;
    logic                drop_q, drop_d;
    logic                wr_en;
    logic [LGSIZE:0]     wr_addr;

    // Read side
    logic                rd_bank_q, rd_bank_d;
    logic [LGSIZE-1:0]   rd_cnt_q, rd_cnt_d;
    logic [4:0]          frame_shift_q, frame_shift_d;
    logic                s1_valid_q, s1_valid_d, s1_sync_q, s1_sync_d, s1_last_q, s1_last_d;
    logic [LGSIZE:0]     s1_addr_q, s1_addr_d;
    logic [4:0]          s1_shift_q, s1_shift_d, s2_shift_q, s2_shift_d;
    logic                s2_valid_q, s2_valid_d, s2_sync_q, s2_sync_d, s2_last_q, s2_last_d;
    logic                s2_bank_q, s2_bank_d;
    logic [2*IWIDTH-1:0] s2_data_q;
    logic                o_valid_q, o_valid_d, o_sync_q, o_sync_d, o_last_q, o_last_d;
    logic [2*OWIDTH-1:0] o_result_q, o_result_d;
    logic                out_bank_q, out_bank_d;
    logic                ovf_q, ovf_d;

    logic                advance, issue, release_hs, wr_bank_free;
    logic [1:0]          release_mask;
    logic [OWIDTH:0]     comp_res [2];

    logic [2*IWIDTH-1:0] mem [0:2*N-1];

    // Returns {saturated, value}: arithmetic shift, round half to even, symmetric clamp.
    function automatic logic [OWIDTH:0] round_sat(input logic [IWIDTH-1:0] x,
                                                  input logic [4:0] sh);
        logic signed [IWIDTH:0] xs, fl, y;
        logic [IWIDTH:0]        mask, rem, half;
        logic                   sat;
        xs   = $signed({x[IWIDTH-1], x});
        fl   = xs >>> sh;
        mask = ~({(IWIDTH+1){1'b1}} << sh);
        rem  = $unsigned(xs) & mask;
        half = {{IWIDTH{1'b0}}, 1'b1} << (sh - 5'd1);
        y    = fl;
        if (sh != 5'd0 && (rem > half || (rem == half && fl[0])))
            y = fl + ONE_S;
        sat = 1'b0;
        if (y > SAT_HI) begin
            y   = SAT_HI;
            sat = 1'b1;
        end else if (y < SAT_LO) begin
            y   = SAT_LO;
            sat = 1'b1;
        end
        return {sat, y[OWIDTH-1:0]};
    endfunction

    for (genvar gi = 0; gi < LGSIZE; gi++) begin : g_bitrev
        assign wr_cnt_rev[gi] = wr_cnt_q[LGSIZE-1-gi];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
        assign comp_res[gi] = round_sat(s2_data_q[gi*IWIDTH +: IWIDTH], s2_shift_q);
    end

    assign wr_addr_lo   = OPT_BITREV ? wr_cnt_rev : wr_cnt_q;
    assign advance      = !o_valid_q || i_ready;
    assign release_hs   = o_valid_q && i_ready && o_last_q;
    assign release_mask = release_hs ? (2'b01 << out_bank_q) : 2'b00;
    // A bank released by this cycle's o_last handshake already counts as free.
    assign wr_bank_free = !full_q[wr_ptr_q] || release_mask[wr_ptr_q];
    assign issue        = advance && full_q[rd_bank_q];

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        full_d     = full_q & ~release_mask;
        drop_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = {wr_ptr_q, wr_addr_lo};
        if (i_ce) begin
            if (i_sync) begin
                if (wr_state_q == WR_ACTIVE || wr_bank_free) begin
                    drop_d     = (wr_state_q == WR_ACTIVE);
                    wr_en      = 1'b1;
                    wr_addr    = {wr_ptr_q, {LGSIZE{1'b0}}};
                    wr_cnt_d   = ONE_ADDR;
                    wr_state_d = WR_ACTIVE;
                end else begin
                    drop_d = 1'b1;
                end
            end else if (wr_state_q == WR_ACTIVE) begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + ONE_ADDR;
                if (wr_cnt_q == LAST_ADDR) begin
                    full_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d         = ~wr_ptr_q;
                    wr_cnt_d         = '0;
                    wr_state_d       = WR_IDLE;
                end
            end
        end
    end

    always_comb begin
        rd_cnt_d      = rd_cnt_q;
        rd_bank_d     = rd_bank_q;
        frame_shift_d = frame_shift_q;
        s1_valid_d    = s1_valid_q;
        s1_addr_d     = s1_addr_q;
        s1_sync_d     = s1_sync_q;
        s1_last_d     = s1_last_q;
        s1_shift_d    = s1_shift_q;
        s2_valid_d    = s2_valid_q;
        s2_sync_d     = s2_sync_q;
        s2_last_d     = s2_last_q;
        s2_shift_d    = s2_shift_q;
        s2_bank_d     = s2_bank_q;
        o_valid_d     = o_valid_q;
        o_sync_d      = o_sync_q;
        o_last_d      = o_last_q;
        o_result_d    = o_result_q;
        out_bank_d    = out_bank_q;
        ovf_d         = ovf_q;
        if (issue) begin
            rd_cnt_d = rd_cnt_q + ONE_ADDR;
            if (rd_cnt_q == '0)
                frame_shift_d = i_shift;
            if (rd_cnt_q == LAST_ADDR) begin
                rd_cnt_d  = '0;
                rd_bank_d = ~rd_bank_q;
            end
        end
        // The whole pipeline moves as one; a stalled output freezes every stage.
        if (advance) begin
            s1_valid_d = issue;
            s1_addr_d  = {rd_bank_q, rd_cnt_q};
            s1_sync_d  = issue && (rd_cnt_q == '0);
            s1_last_d  = issue && (rd_cnt_q == LAST_ADDR);
            s1_shift_d = (rd_cnt_q == '0) ? i_shift : frame_shift_q;
            s2_valid_d = s1_valid_q;
            s2_sync_d  = s1_sync_q;
            s2_last_d  = s1_last_q;
            s2_shift_d = s1_shift_q;
            s2_bank_d  = s1_addr_q[LGSIZE];
            o_valid_d  = s2_valid_q;
            o_sync_d   = s2_valid_q && s2_sync_q;
            o_last_d   = s2_valid_q && s2_last_q;
            out_bank_d = s2_bank_q;
            if (s2_valid_q) begin
                o_result_d = {comp_res[1][OWIDTH-1:0], comp_res[0][OWIDTH-1:0]};
                ovf_d      = ovf_q | comp_res[1][OWIDTH] | comp_res[0][OWIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_addr] <= i_sample;
        if (advance)
            s2_data_q <= mem[s1_addr_q];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_state_q    <= WR_IDLE;
            wr_cnt_q      <= '0;
            wr_ptr_q      <= 1'b0;
            full_q        <= 2'b00;
            drop_q        <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_cnt_q      <= '0;
            frame_shift_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_sync_q     <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_shift_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_sync_q     <= 1'b0;
            s2_last_q     <= 1'b0;
            s2_shift_q    <= '0;
            s2_bank_q     <= 1'b0;
            o_valid_q     <= 1'b0;
            o_sync_q      <= 1'b0;
            o_last_q      <= 1'b0;
            o_result_q    <= '0;
            out_bank_q    <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_cnt_q      <= wr_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            full_q        <= full_d;
            drop_q        <= drop_d;
            rd_bank_q     <= rd_bank_d;
            rd_cnt_q      <= rd_cnt_d;
            frame_shift_q <= frame_shift_d;
            s1_valid_q    <= s1_valid_d;
            s1_addr_q     <= s1_addr_d;
            s1_sync_q     <= s1_sync_d;
            s1_last_q     <= s1_last_d;
            s1_shift_q    <= s1_shift_d;
            s2_valid_q    <= s2_valid_d;
            s2_sync_q     <= s2_sync_d;
            s2_last_q     <= s2_last_d;
            s2_shift_q    <= s2_shift_d;
            s2_bank_q     <= s2_bank_d;
            o_valid_q     <= o_valid_d;
            o_sync_q      <= o_sync_d;
            o_last_q      <= o_last_d;
            o_result_q    <= o_result_d;
            out_bank_q    <= out_bank_d;
            ovf_q         <= ovf_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_result   = o_result_q;
    assign o_sync     = o_sync_q;
    assign o_last     = o_last_q;
    assign o_overflow = ovf_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_fft_reorder_stream.sv
// Directed bench for fft_reorder_stream at N=8, 8-bit input, 6-bit output.
module tb_fft_reorder_stream;

    localparam int LG = 3;
    localparam int IW = 8;
    localparam int OW = 6;
    localparam int N  = 8;

    logic              clk;
    logic              i_reset, i_ce, i_sync, i_ready;
    logic [2*IW-1:0]   i_sample;
    logic [4:0]        i_shift;
    logic              o_valid, o_sync, o_last, o_overflow, o_drop;
    logic [2*OW-1:0]   o_result;

    int checks = 0;
    int errors = 0;

    int in_re [8];
    int in_im [8];
    int BR    [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int er    [8];
    int ei    [8];

    int got_re [$];
    int got_im [$];
    int got_sy [$];
    int got_la [$];
    int exp_re [$];
    int exp_im [$];

    bit rand_ready  = 1'b0;
    bit ready_fixed = 1'b1;

    fft_reorder_stream #(
        .LGSIZE(LG), .IWIDTH(IW), .OWIDTH(OW), .OPT_BITREV(1'b1)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync),
        .i_sample(i_sample), .i_shift(i_shift), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_sync(o_sync),
        .o_last(o_last), .o_overflow(o_overflow), .o_drop(o_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Ready driver: fixed level or pseudo-random, applied just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Output monitor: records handshaken beats, verifies stability while stalled.
    initial begin
        bit stall_prev = 1'b0;
        int held_res = 0, held_sy = 0, held_la = 0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                check_eq("stall_valid",  int'(o_valid), 1);
                check_eq("stall_result", int'(o_result), held_res);
                check_eq("stall_sync",   int'(o_sync), held_sy);
                check_eq("stall_last",   int'(o_last), held_la);
            end
            stall_prev = o_valid && !i_ready && !i_reset;
            held_res   = int'(o_result);
            held_sy    = int'(o_sync);
            held_la    = int'(o_last);
            if (o_valid && i_ready && !i_reset) begin
                got_re.push_back(int'($signed(o_result[2*OW-1:OW])));
                got_im.push_back(int'($signed(o_result[OW-1:0])));
                got_sy.push_back(int'(o_sync));
                got_la.push_back(int'(o_last));
                $display("beat %0d: re=%0d im=%0d sync=%0d last=%0d", got_re.size() - 1,
                         got_re[$], got_im[$], got_sy[$], got_la[$]);
            end
        end
    end

    task automatic clear_queues();
        got_re.delete(); got_im.delete(); got_sy.delete(); got_la.delete();
        exp_re.delete(); exp_im.delete();
    endtask

    task automatic push_reordered();
        for (int a = 0; a < N; a++) begin
            exp_re.push_back(in_re[BR[a]]);
            exp_im.push_back(in_im[BR[a]]);
        end
    endtask

    task automatic push_list();
        for (int a = 0; a < N; a++) begin
            exp_re.push_back(er[a]);
            exp_im.push_back(ei[a]);
        end
    endtask

    task automatic send_frame(input int nsamp, input bit exp_drop);
        for (int k = 0; k < nsamp; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check_eq("drop_pulse", int'(o_drop), int'(exp_drop));
            if (k == 2) check_eq("drop_clear", int'(o_drop), 0);
            i_ce     = 1'b1;
            i_sync   = (k == 0);
            i_sample = {IW'(in_re[k]), IW'(in_im[k])};
        end
        @(posedge clk);
        #1;
        i_ce   = 1'b0;
        i_sync = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (got_re.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_beats(input string tag);
        check_eq({tag, "_count"}, got_re.size(), exp_re.size());
        for (int i = 0; i < exp_re.size() && i < got_re.size(); i++) begin
            check_eq($sformatf("%s_re%0d", tag, i), got_re[i], exp_re[i]);
            check_eq($sformatf("%s_im%0d", tag, i), got_im[i], exp_im[i]);
            check_eq($sformatf("%s_sync%0d", tag, i), got_sy[i], int'(i % N == 0));
            check_eq($sformatf("%s_last%0d", tag, i), got_la[i], int'(i % N == N - 1));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"},    int'(o_valid), 0);
        check_eq({tag, "_sync"},     int'(o_sync), 0);
        check_eq({tag, "_last"},     int'(o_last), 0);
        check_eq({tag, "_overflow"}, int'(o_overflow), 0);
        check_eq({tag, "_drop"},     int'(o_drop), 0);
        check_eq({tag, "_result"},   int'(o_result), 0);
    endtask

    initial begin
        i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_sample = '0; i_shift = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Reorder and latency
        clear_queues();
        for (int k = 0; k < N; k++) begin
            in_re[k] = k;
            in_im[k] = 7 - k;
        end
        send_frame(8, 1'b0);
        @(negedge clk); check_eq("lat_c1", int'(o_valid), 0);
        @(negedge clk); check_eq("lat_c2", int'(o_valid), 0);
        @(negedge clk); check_eq("lat_c3", int'(o_valid), 0);
        @(negedge clk); check_eq("lat_c4", int'(o_valid), 1);
        wait_beats(8);
        settle(5);
        er = '{0, 4, 2, 6, 1, 5, 3, 7};
        ei = '{7, 3, 5, 1, 6, 2, 4, 0};
        push_list();
        compare_beats("reorder");

        // Convergent rounding; shift changed mid-frame must not apply
        clear_queues();
        i_shift = 5'd2;
        in_re = '{6, 10, 14, -6, -10, 0, 0, 0};
        in_im = '{2, 3, -2, 5, 7, 0, 0, 0};
        send_frame(8, 1'b0);
        wait_beats(1);
        i_shift = 5'd0;
        wait_beats(8);
        settle(5);
        er = '{2, -2, 4, 0, 2, 0, -2, 0};
        ei = '{0, 2, 0, 0, 1, 0, 1, 0};
        push_list();
        compare_beats("round");
        check_eq("round_ovf", int'(o_overflow), 0);

        // Saturation
        clear_queues();
        in_re = '{100, -128, 5, 0, 0, 0, 0, 0};
        in_im = '{-100, 31, -31, 0, 0, 0, 0, 0};
        send_frame(8, 1'b0);
        wait_beats(8);
        settle(5);
        er = '{31, 0, 5, 0, -31, 0, 0, 0};
        ei = '{-31, 0, -31, 0, 31, 0, 0, 0};
        push_list();
        compare_beats("sat");
        check_eq("sat_ovf", int'(o_overflow), 1);

        // Backpressure over four frames
        clear_queues();
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) begin
                in_re[k] = f * 8 + k - 16;
                in_im[k] = 15 - (f * 8 + k);
            end
            push_reordered();
            send_frame(8, 1'b0);
            if (f == 1) wait_beats(8);
            if (f == 2) wait_beats(16);
        end
        wait_beats(32);
        settle(10);
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        compare_beats("bp");
        check_eq("bp_ovf_sticky", int'(o_overflow), 1);

        // Overload: third frame dropped while both banks are held
        ready_fixed = 1'b0;
        settle(2);
        clear_queues();
        for (int k = 0; k < N; k++) begin in_re[k] = k;      in_im[k] = -k;     end
        push_reordered();
        send_frame(8, 1'b0);
        for (int k = 0; k < N; k++) begin in_re[k] = 10 + k; in_im[k] = k - 10; end
        push_reordered();
        send_frame(8, 1'b0);
        for (int k = 0; k < N; k++) begin in_re[k] = 20;     in_im[k] = -20;    end
        send_frame(8, 1'b1);
        settle(5);
        check_eq("ovl_held_valid", int'(o_valid), 1);
        ready_fixed = 1'b1;
        wait_beats(16);
        settle(20);
        compare_beats("overload");

        // Mid-frame sync at counter 5 restarts the bank
        clear_queues();
        for (int k = 0; k < N; k++) begin in_re[k] = 25; in_im[k] = -25; end
        send_frame(5, 1'b0);
        for (int k = 0; k < N; k++) begin in_re[k] = 3 * k - 10; in_im[k] = 12 - 2 * k; end
        push_reordered();
        send_frame(8, 1'b1);
        wait_beats(8);
        settle(10);
        compare_beats("restart");

        // Reset during readout
        clear_queues();
        for (int k = 0; k < N; k++) begin in_re[k] = 9; in_im[k] = -9; end
        send_frame(8, 1'b0);
        wait_beats(3);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        i_reset = 1'b0;
        clear_queues();
        in_re = '{31, -31, 1, 2, 3, 4, 5, 6};
        in_im = '{-1, -2, -3, -4, -5, -6, -7, -8};
        send_frame(8, 1'b0);
        wait_beats(8);
        settle(10);
        er = '{31, 3, 1, 5, -31, 4, 2, 6};
        ei = '{-1, -5, -3, -7, -2, -6, -4, -8};
        push_list();
        compare_beats("postreset");
        check_eq("postreset_ovf", int'(o_overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
